set_mode_ctrl: RTL
==================

Name: set_mode_ctrl

Overview:
- Front-panel configuration controller for the digital clock/alarm subsystem.
- Debounces three raw pushbuttons (mode, select, increment) and runs a mode FSM.
- Drives the setting interface of the timekeeper and the alarm block: set-enable, hour/minute select, and single-cycle increment pulses, with long-press auto-repeat.
- Returns to run mode automatically after a period with no button activity.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a synchronised button level is accepted.
- LONG_PRESS_CYCLES, 25000000: increment held this many cycles after its press event before auto-repeat starts.
- REPEAT_CYCLES, 5000000: period between auto-repeat increment pulses.
- TIMEOUT_CYCLES, 500000000: cycles with no press event in a set state before forced return to RUN.
- CNT_W, 32: width of all internal counters; must hold the largest parameter.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- btn_mode, input, 1: raw mode button, active-high, asynchronous to clk.
- btn_sel, input, 1: raw hour/minute select button, active-high, asynchronous.
- btn_inc, input, 1: raw increment button, active-high, asynchronous.
- time_set_en, output, 1: 1 while setting the current time.
- alarm_set_en, output, 1: 1 while setting the alarm.
- set_hr_or_min, output, 1: 0 = hour field, 1 = minute field.
- inc_pulse, output, 1: one-cycle increment strobe to the enabled target.
- state_code, output, 3: FSM state for display (RUN=0, T_HR=1, T_MIN=2, A_HR=3, A_MIN=4).

Behaviour:
- Clock and reset:
  - One clock: clk. Reset rst is synchronous and active-high.
  - On rst, all outputs are 0 and state is RUN.
  - Synchronisers, debounced levels and all counters clear on rst.
  - rst asserted mid-operation (including mid-repeat) takes effect at the next edge; no pulse is issued after it.
- Input conditioning, per button:
  - 2-flop synchroniser, then a debounce counter.
  - The debounced level changes only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count.
  - Press event = one-cycle rising edge of the debounced level. Release generates no event.
- FSM transitions (registered; outputs update on the edge after the press event):
  - mode press: RUN->T_HR; T_HR or T_MIN->A_HR; A_HR or A_MIN->RUN.
  - sel press: T_HR<->T_MIN, A_HR<->A_MIN; ignored in RUN.
  - inc press: no state change.
- Outputs per state:
  - RUN: time_set_en=0, alarm_set_en=0, set_hr_or_min=0.
  - T_HR: time_set_en=1, set_hr_or_min=0. T_MIN: time_set_en=1, set_hr_or_min=1.
  - A_HR: alarm_set_en=1, set_hr_or_min=0. A_MIN: alarm_set_en=1, set_hr_or_min=1.
  - time_set_en and alarm_set_en are never both 1.
- Increment:
  - In any set state, an inc press event produces inc_pulse=1 for exactly one cycle, on the edge after the event.
  - If the debounced inc stays high, the first repeat pulse comes LONG_PRESS_CYCLES after the press pulse, then one every REPEAT_CYCLES.
  - Repeat stops on release, state change, or timeout. A new press is required to resume.
  - In RUN, inc is ignored and no repeat runs.
- Simultaneous press events in one cycle:
  - Priority is mode > sel > inc. Only the highest is acted on; the others are discarded, not queued.
  - A held inc whose press was discarded does not auto-repeat.
- Timeout:
  - Counter clears on every press event and on state entry.
  - In a set state, reaching TIMEOUT_CYCLES forces RUN on the next edge.
  - Auto-repeat pulses do not clear the timeout counter.
- Hour/minute wrap-around is the target's responsibility; this block issues unbounded pulses.

Test Plan (override DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, REPEAT_CYCLES=5, TIMEOUT_CYCLES=100):
- Reset, then btn_mode high for 10 cycles -> state_code 0->1 once; time_set_en=1, set_hr_or_min=0; no inc_pulse.
- A 3-cycle glitch on btn_inc in T_HR -> no inc_pulse. An 8-cycle press -> exactly one inc_pulse, 1 cycle wide.
- Hold btn_inc for 45 debounced cycles in A_MIN -> pulses at press+1, +21, +26, +31, +36, +41 (6 total); none after release.
- Mode presses from RUN: 0->1->3->0. sel in T_HR -> 2; sel again -> 1. sel in RUN -> stays 0.
- mode and inc debounced in the same cycle in T_MIN -> state 3, no inc_pulse. Continue holding inc -> no repeat.
- Enter T_HR with no activity for 100 cycles -> state 0, enables 0. rst asserted during auto-repeat -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/set_mode_ctrl.sv
// set_mode_ctrl: front-panel controller for the clock/alarm subsystem. Debounces the
//   mode/select/increment buttons and steps a mode FSM that drives the setting
//   interface of the timekeeper and alarm blocks, with long-press auto-repeat.
// Latency: a raw edge reaches the debounced level 2 sync + DEBOUNCE_CYCLES edges later;
//   state and inc_pulse update on the edge after the press event. No backpressure.
// Ports: clk/rst (sync, active-high); btn_mode/btn_sel/btn_inc raw async buttons;
//   time_set_en/alarm_set_en/set_hr_or_min setting selects; inc_pulse one-cycle strobe;
//   state_code FSM state for display.
module set_mode_ctrl #(
   parameter int DEBOUNCE_CYCLES   = 500000,
   parameter int LONG_PRESS_CYCLES = 25000000,
   parameter int REPEAT_CYCLES     = 5000000,
   parameter int TIMEOUT_CYCLES    = 500000000,
   parameter int CNT_W             = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_sel,
   input  logic       btn_inc,
   output logic       time_set_en,
   output logic       alarm_set_en,
   output logic       set_hr_or_min,
   output logic       inc_pulse,
   output logic [2:0] state_code
);

   typedef enum logic [2:0] {
      S_RUN   = 3'd0,
      S_T_HR  = 3'd1,
      S_T_MIN = 3'd2,
      S_A_HR  = 3'd3,
      S_A_MIN = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   // Button vectors: bit 0 = mode, bit 1 = sel, bit 2 = inc.
   logic [2:0]       w_btn_raw;
   logic [2:0]       r_sync1;
   logic [2:0]       r_sync2;
   logic [2:0]       r_deb;
   logic [2:0]       r_deb_q;
   logic [CNT_W-1:0] r_deb_cnt [3];

   logic [2:0]       w_press;
   logic             w_mode_ev;
   logic             w_sel_ev;
   logic             w_inc_ev;
   logic             w_any_ev;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_set_state;
   logic             w_state_hold;
   logic             w_timeout;
   logic [CNT_W-1:0] r_to_cnt;

   logic             r_rep_act;
   logic             r_rep_first;
   logic [CNT_W-1:0] r_rep_cnt;
   logic [CNT_W-1:0] w_rep_lim;
   logic             w_rep_fire;
   logic             r_inc_pulse;

   assign w_btn_raw = {btn_inc, btn_sel, btn_mode};

   // Synchroniser and debounce: the accepted level follows the synchronised level
   // only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_deb   <= '0;
         r_deb_q <= '0;
         for (int i = 0; i < 3; i++) r_deb_cnt[i] <= '0;
      end else begin
         r_sync1 <= w_btn_raw;
         r_sync2 <= r_sync1;
         r_deb_q <= r_deb;
         for (int i = 0; i < 3; i++) begin
            if (r_sync2[i] != r_deb[i]) begin
               if (r_deb_cnt[i] == DEB_LAST) begin
                  r_deb[i]     <= r_sync2[i];
                  r_deb_cnt[i] <= '0;
               end else begin
                  r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
               end
            end else begin
               r_deb_cnt[i] <= '0;
            end
         end
      end
   end

   // Press events with mode > sel > inc priority; lower ones are dropped, not queued.
   assign w_press   = r_deb & ~r_deb_q;
   assign w_mode_ev = w_press[0];
   assign w_sel_ev  = w_press[1] & ~w_press[0];
   assign w_inc_ev  = w_press[2] & ~(|w_press[1:0]);
   assign w_any_ev  = |w_press;

   assign w_set_state  = (r_state != S_RUN);
   // A press in the same cycle keeps the set state alive, so it wins over timeout.
   assign w_timeout    = w_set_state && (r_to_cnt == TO_LAST) && !w_any_ev;
   assign w_state_hold = (w_state_nxt == r_state);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_RUN;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      time_set_en   = 1'b0;
      alarm_set_en  = 1'b0;
      set_hr_or_min = 1'b0;

      if (w_mode_ev) begin
         case (r_state)
            S_RUN:            w_state_nxt = S_T_HR;
            S_T_HR, S_T_MIN:  w_state_nxt = S_A_HR;
            default:          w_state_nxt = S_RUN;
         endcase
      end else if (w_sel_ev) begin
         case (r_state)
            S_T_HR:  w_state_nxt = S_T_MIN;
            S_T_MIN: w_state_nxt = S_T_HR;
            S_A_HR:  w_state_nxt = S_A_MIN;
            S_A_MIN: w_state_nxt = S_A_HR;
            default: w_state_nxt = r_state;
         endcase
      end else if (w_timeout) begin
         w_state_nxt = S_RUN;
      end

      case (r_state)
         S_T_HR:  time_set_en = 1'b1;
         S_T_MIN: begin time_set_en = 1'b1; set_hr_or_min = 1'b1; end
         S_A_HR:  alarm_set_en = 1'b1;
         S_A_MIN: begin alarm_set_en = 1'b1; set_hr_or_min = 1'b1; end
         default: ;
      endcase
   end

   // Idle timeout: cleared on any press event and on every state entry.
   always_ff @(posedge clk) begin
      if (rst || !w_set_state || w_any_ev || !w_state_hold) r_to_cnt <= '0;
      else                                                 r_to_cnt <= r_to_cnt + 1'b1;
   end

   // Auto-repeat: armed only by an accepted inc press in a set state. The first repeat
   // waits LONG_PRESS_CYCLES after the press pulse, later ones REPEAT_CYCLES apart.
   assign w_rep_lim  = r_rep_first ? LP_LAST : RP_LAST;
   assign w_rep_fire = r_rep_act && r_deb[2] && w_state_hold && (r_rep_cnt == w_rep_lim);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rep_act   <= 1'b0;
         r_rep_first <= 1'b0;
         r_rep_cnt   <= '0;
         r_inc_pulse <= 1'b0;
      end else begin
         r_inc_pulse <= (w_inc_ev && w_set_state) || w_rep_fire;
         if (w_inc_ev && w_set_state) begin
            r_rep_act   <= 1'b1;
            r_rep_first <= 1'b1;
            r_rep_cnt   <= '0;
         end else if (!r_rep_act || !r_deb[2] || !w_state_hold) begin
            r_rep_act <= 1'b0;
            r_rep_cnt <= '0;
         end else if (w_rep_fire) begin
            r_rep_first <= 1'b0;
            r_rep_cnt   <= '0;
         end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
         end
      end
   end

   assign inc_pulse  = r_inc_pulse;
   assign state_code = r_state;

endmodule
